// File: rtl/output_argmax_pkg.sv
// Shared definitions for the output argmax stage: FSM encoding and width helpers.
// Imported by the top level and by the comparator.
package output_argmax_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    DRAIN,
    DONE,
    RESTART
  } state_t;

  function automatic int score_width(input int indata_width);
    return indata_width + 3;
  endfunction

  function automatic bit class_width_ok(input int class_width, input int nn2);
    return (1 << class_width) >= nn2;
  endfunction

endpackage

// File: rtl/output_argmax_cmp.sv
// Combinational signed running-max step: keeps the current best unless the
// candidate is strictly greater, or init forces the candidate in.
module argmax_cmp #(
  parameter int SW = 29,
  parameter int IW = 4
) (
  input  logic          init,
  input  logic [SW-1:0] cand,
  input  logic [IW-1:0] cand_idx,
  input  logic [SW-1:0] cur_max,
  input  logic [IW-1:0] cur_idx,
  output logic [SW-1:0] new_max,
  output logic [IW-1:0] new_idx
);

  logic take;

  // Strict compare so equal scores keep the earlier (lower) index.
  assign take    = init | ($signed(cand) > $signed(cur_max));
  assign new_max = take ? cand : cur_max;
  assign new_idx = take ? cand_idx : cur_idx;

endmodule

// File: rtl/output_argmax.sv
// Drains the output layer's score words, buffers them, tracks the signed
// argmax and hands the predicted class over a valid/ack handshake.
module output_argmax
  import output_argmax_pkg::*;
#(
  parameter  int INDATA_WIDTH = 26,
  parameter  int NN2          = 10,
  parameter  int CLASS_WIDTH  = 4,
  localparam int SW           = score_width(INDATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   neurons_finished,
  input  logic                   transferred,
  input  logic [SW-1:0]          sout_in,
  output logic                   shift_o,
  output logic                   restart_o,
  output logic                   result_valid,
  input  logic                   result_ack,
  output logic [CLASS_WIDTH-1:0] class_idx,
  output logic [SW-1:0]          max_score,
  output logic                   busy,
  input  logic [CLASS_WIDTH-1:0] rd_idx,
  output logic [SW-1:0]          rd_data
);

  localparam int CNT_W = CLASS_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(NN2 - 1);
  localparam logic [CNT_W-1:0] NN2_CNT    = CNT_W'(NN2);

  generate
    if (!class_width_ok(CLASS_WIDTH, NN2)) begin : g_bad_class_width
      $error("output_argmax: CLASS_WIDTH too small for NN2");
    end
  endgenerate

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   shift_q, shift_d;
  logic                   restart_q, restart_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic [CLASS_WIDTH-1:0] class_q, class_d;
  logic [SW-1:0]          max_q, max_d;
  logic [SW-1:0]          buf_q [NN2];
  logic [SW-1:0]          buf_d [NN2];

  logic                   capture;
  logic [CLASS_WIDTH-1:0] cap_idx;
  logic [SW-1:0]          cmp_max;
  logic [CLASS_WIDTH-1:0] cmp_idx;

  // Capture lags shift by one cycle: word k lands while the counter reads k+1.
  assign capture = ((state_q == SHIFT) && (cnt_q != '0)) || (state_q == DRAIN);
  assign cap_idx = CLASS_WIDTH'(cnt_q - 1'b1);

  argmax_cmp #(
    .SW (SW),
    .IW (CLASS_WIDTH)
  ) u_cmp (
    .init     (cap_idx == '0),
    .cand     (sout_in),
    .cand_idx (cap_idx),
    .cur_max  (max_q),
    .cur_idx  (class_q),
    .new_max  (cmp_max),
    .new_idx  (cmp_idx)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    restart_d = 1'b0;
    valid_d   = valid_q;
    class_d   = class_q;
    max_d     = max_q;
    buf_d     = buf_q;

    if (capture) begin
      max_d   = cmp_max;
      class_d = cmp_idx;
      for (int i = 0; i < NN2; i++) begin
        if (cap_idx == CLASS_WIDTH'(i)) buf_d[i] = sout_in;
      end
    end

    case (state_q)
      IDLE: begin
        if (neurons_finished) begin
          state_d = SHIFT;
          shift_d = 1'b1;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_SHIFT) begin
          shift_d = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
        valid_d = 1'b1;
      end
      DONE: begin
        if (result_ack && transferred) begin
          valid_d   = 1'b0;
          restart_d = 1'b1;
          state_d   = RESTART;
        end
      end
      RESTART: begin
        // Hold off until the stale finished flag clears to avoid re-triggering.
        if (!neurons_finished) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        shift_d = 1'b0;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= 1'b0;
      restart_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      class_q   <= '0;
      max_q     <= '0;
      for (int i = 0; i < NN2; i++) buf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      restart_q <= restart_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      class_q   <= class_d;
      max_q     <= max_d;
      buf_q     <= buf_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_idx} < NN2_CNT) rd_data = buf_q[rd_idx];
  end

  assign shift_o      = shift_q;
  assign restart_o    = restart_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;
  assign class_idx    = class_q;
  assign max_score    = max_q;

endmodule

// File: tb/tb_output_argmax.sv
// Directed bench for output_argmax: models the output layer's shift register
// and checks argmax, latency, handshake, buffer reads and mid-run reset.
module tb_output_argmax;

  logic        clk;
  logic        rstn;
  logic        neurons_finished;
  logic        transferred;
  logic [28:0] sout_in;
  logic        shift_o;
  logic        restart_o;
  logic        result_valid;
  logic        result_ack;
  logic [3:0]  class_idx;
  logic [28:0] max_score;
  logic        busy;
  logic [3:0]  rd_idx;
  logic [28:0] rd_data;

  logic [28:0] words [10];
  int          total;
  int          bad;

  output_argmax #(
    .INDATA_WIDTH (26),
    .NN2          (10),
    .CLASS_WIDTH  (4)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .neurons_finished (neurons_finished),
    .transferred      (transferred),
    .sout_in          (sout_in),
    .shift_o          (shift_o),
    .restart_o        (restart_o),
    .result_valid     (result_valid),
    .result_ack       (result_ack),
    .class_idx        (class_idx),
    .max_score        (max_score),
    .busy             (busy),
    .rd_idx           (rd_idx),
    .rd_data          (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Triggers one inference, plays the output layer's shift register, and
  // checks shift count, trigger-to-valid latency and the argmax result.
  task automatic applyStimulus(input string tag, input logic [3:0] exp_cls, input logic [28:0] exp_max);
    int   n;
    int   shifts;
    int   lat;
    logic pend;
    n      = 0;
    shifts = 0;
    lat    = 0;
    pend   = 1'b0;
    @(negedge clk);
    neurons_finished = 1'b1;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      @(posedge clk);
      #1;
      if (pend && n < 10) begin
        sout_in = words[n];
        n++;
      end
      @(negedge clk);
      pend = shift_o;
      if (shift_o) shifts++;
      if (result_valid) lat = c;
    end
    checkOutput({tag, "_shifts"}, 32'(shifts), 32'd10);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd12);
    checkOutput({tag, "_class"}, 32'(class_idx), 32'(exp_cls));
    checkOutput({tag, "_max"}, 32'(max_score), 32'(exp_max));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  // Accepts the result and walks the block back to IDLE, checking the
  // single-cycle restart pulse and the wait on neurons_finished.
  task automatic doAck(input string tag);
    @(negedge clk);
    transferred = 1'b1;
    result_ack  = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_restart_hi"}, 32'(restart_o), 32'd1);
    checkOutput({tag, "_valid_clr"}, 32'(result_valid), 32'd0);
    result_ack  = 1'b0;
    transferred = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_restart_lo"}, 32'(restart_o), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_restart_wait"}, 32'(busy), 32'd1);
    neurons_finished = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int rs;
    total            = 0;
    bad              = 0;
    rstn             = 1'b0;
    neurons_finished = 1'b0;
    transferred      = 1'b0;
    result_ack       = 1'b0;
    sout_in          = '0;
    rd_idx           = 4'd4;
    #23;
    checkOutput("rst_shift", 32'(shift_o), 32'd0);
    checkOutput("rst_restart", 32'(restart_o), 32'd0);
    checkOutput("rst_valid", 32'(result_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_class", 32'(class_idx), 32'd0);
    checkOutput("rst_max", 32'(max_score), 32'd0);
    checkOutput("rst_buf", 32'(rd_data), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] basic scores");
    words = '{29'd5, 29'(-3), 29'd12, 29'd0, 29'd7, 29'd1, 29'd2, 29'd3, 29'd4, 29'd6};
    applyStimulus("basic", 4'd2, 29'd12);
    rd_idx = 4'd4;
    #1 checkOutput("basic_rd4", 32'(rd_data), 32'd7);
    rd_idx = 4'd9;
    #1 checkOutput("basic_rd9", 32'(rd_data), 32'd6);
    rd_idx = 4'd1;
    #1 checkOutput("basic_rd1", 32'(rd_data), 32'h1FFFFFFD);
    rd_idx = 4'd12;
    #1 checkOutput("basic_rd_oob", 32'(rd_data), 32'd0);

    $display("[TB] ack without transferred must not release");
    @(negedge clk);
    result_ack = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("proto_valid_held", 32'(result_valid), 32'd1);
    checkOutput("proto_no_restart", 32'(restart_o), 32'd0);
    checkOutput("proto_class_held", 32'(class_idx), 32'd2);
    result_ack = 1'b0;
    doAck("basic");

    $display("[TB] all equal negative");
    words = '{29'h1FFFFFFF, 29'h1FFFFFFF, 29'h1FFFFFFF, 29'h1FFFFFFF, 29'h1FFFFFFF,
              29'h1FFFFFFF, 29'h1FFFFFFF, 29'h1FFFFFFF, 29'h1FFFFFFF, 29'h1FFFFFFF};
    applyStimulus("equal", 4'd0, 29'h1FFFFFFF);
    doAck("equal");

    $display("[TB] tie resolves low");
    words = '{29'd1, 29'd2, 29'd0, 29'd9, 29'(-4), 29'd5, 29'd3, 29'd7, 29'd9, 29'd8};
    applyStimulus("tie", 4'd3, 29'd9);
    doAck("tie");

    $display("[TB] extremes");
    words = '{29'h10000000, 29'd100, 29'(-50), 29'd3, 29'd77,
              29'd0, 29'(-1), 29'd200, 29'd5, 29'h0FFFFFFF};
    applyStimulus("ext", 4'd9, 29'h0FFFFFFF);
    rd_idx = 4'd0;
    #1 checkOutput("ext_rd0", 32'(rd_data), 32'h10000000);
    doAck("ext");

    $display("[TB] reset mid shift");
    rd_idx = 4'd4;
    rs     = 0;
    @(negedge clk);
    neurons_finished = 1'b1;
    for (int c = 0; c < 20 && rs < 5; c++) begin
      @(negedge clk);
      if (shift_o) rs++;
    end
    checkOutput("mid_shift_seen", 32'(rs), 32'd5);
    rstn             = 1'b0;
    neurons_finished = 1'b0;
    #1;
    checkOutput("mid_shift_drop", 32'(shift_o), 32'd0);
    checkOutput("mid_valid", 32'(result_valid), 32'd0);
    checkOutput("mid_class", 32'(class_idx), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_buf_clr", 32'(rd_data), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    words = '{29'd5, 29'(-3), 29'd12, 29'd0, 29'd7, 29'd1, 29'd2, 29'd3, 29'd4, 29'd6};
    applyStimulus("rerun", 4'd2, 29'd12);
    rd_idx = 4'd4;
    #1 checkOutput("rerun_rd4", 32'(rd_data), 32'd7);
    doAck("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_argmax.md
Name: output_argmax

Overview:
- Final stage of the network. It sits directly downstream of the second (output) neuron layer.
- When the output layer reports all neurons finished, this block drains the layer's serial parallel-in/serial-out register one word per shift and buffers the scores.
- It computes the signed argmax (predicted class) and presents it with a valid/ack handshake, then releases the output layer for the next inference with a restart pulse.

Parameters:
- INDATA_WIDTH, 26, base data width; score width is SW = INDATA_WIDTH+3.
- NN2, 10, number of output-layer neurons (classes).
- CLASS_WIDTH, 4, width of class index; must satisfy 2^CLASS_WIDTH >= NN2.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- neurons_finished  in  1  output layer has all neuron results latched
- transferred  in  1  output layer has shifted out all NN2 words
- sout_in  in  SW  serial word from output layer, two's-complement fixed point
- shift_o  out  1  shift request to output layer
- restart_o  out  1  one-cycle restart pulse to output layer
- result_valid  out  1  class_idx/max_score valid
- result_ack  in  1  consumer accepts result
- class_idx  out  CLASS_WIDTH  index of maximum score
- max_score  out  SW  maximum score value
- busy  out  1  high in any state other than IDLE
- rd_idx  in  CLASS_WIDTH  score buffer read address
- rd_data  out  SW  combinational read of score buffer[rd_idx]; 0 if rd_idx >= NN2

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; shift_o, restart_o, result_valid, busy = 0; class_idx, max_score = 0; word counter = 0; score buffer cleared to 0.
- The FSM uses states IDLE, SHIFT, DRAIN, DONE, RESTART. All outputs are registered except rd_data.
- IDLE:
  - On neurons_finished=1, go to SHIFT with shift_o=1 and counter=0.
- SHIFT:
  - shift_o stays high for exactly NN2 consecutive cycles.
  - Word k appears on sout_in one cycle after the k-th shift cycle.
  - The block captures sout_in on each rising edge starting with the edge after the first shift cycle, so capture lags shift by 1.
  - After NN2 shift cycles, drop shift_o and go to DRAIN.
- DRAIN:
  - Capture the final (NN2-th) word, then go to DONE.
  - Total latency from neurons_finished to result_valid is NN2+2 cycles.
- Capture order: word k is stored in buffer[k]. The first word out is neuron 0, the MSB slice of the output-layer hold register.
- Argmax:
  - Running compare, signed over SW bits, performed on each capture.
  - The first word initialises max_score/class_idx unconditionally.
  - A later word replaces the current max only if strictly greater. Ties therefore resolve to the lowest index.
  - Most negative value (100…0) and all-equal inputs both yield class_idx=0.
- DONE:
  - result_valid=1; class_idx and max_score held stable.
  - On result_ack=1 and transferred=1, clear result_valid, pulse restart_o for 1 cycle, go to RESTART.
  - If result_ack arrives while transferred=0, wait in DONE. This is a protocol error and the bench flags it.
- RESTART:
  - Wait until neurons_finished=0, then go to IDLE. This prevents re-triggering on a stale finished flag.
- Buffer contents persist after IDLE until overwritten by the next run, so they remain readable via rd_idx.
- Simultaneous events:
  - neurons_finished rising while in DONE or RESTART is ignored.
  - result_ack outside DONE is ignored.
- Reset mid-operation (any state) returns immediately to the reset values. shift_o and restart_o drop asynchronously.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, SHIFT, DRAIN, DONE, RESTART)
  - score width function SW = INDATA_WIDTH+3
  - class-index width check
- One sub-module, argmax_cmp: a combinational signed comparator taking candidate, current max and index, producing the updated max and index. It is reusable for any later top-k stage.

Test Plan:
- Scores {5,-3,12,0,7,1,2,3,4,6} (scaled to Q format) after neurons_finished -> exactly 10 shift_o cycles; result_valid 12 cycles after trigger; class_idx=2; max_score=12; rd_idx=4 reads 7.
- All ten scores equal to -1 -> class_idx=0; max_score=-1.
- Tie 9 at indices 3 and 8, others lower -> class_idx=3.
- Scores with index 9 = 0x0FFFFFFF (max positive) and index 0 = 0x10000000 (min negative) -> class_idx=9.
- DONE with transferred=1, result_ack asserted -> restart_o high exactly 1 cycle; block stays in RESTART until neurons_finished falls; a second inference yields the new result.
- rstn asserted at shift cycle 5 -> shift_o drops immediately; result_valid=0; class_idx=0; a subsequent trigger runs a full clean 10-word drain.
